// File: rtl/pipe_control_unit.sv
// pipe_control_unit: registered RV32I(M) decode stage feeding the ID/EX register.
// Decodes the IF/ID instruction into the datapath control bundle and adds
// valid/ready handshake, load-use bubbles, flush and multi-cycle M-op hold.
module pipe_control_unit #(
    parameter logic EN_MEXT = 1'b1,
    parameter int   MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_vld,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        id_ready,
    output logic        ctrl_vld,
    output logic        pc_sel,
    output logic        br_unsign,
    output logic        op1_sel,
    output logic        op2_sel,
    output logic        rd_wren,
    output logic        mem_wren,
    output logic [4:0]  alu_opcode,
    output logic [1:0]  wb_sel,
    output logic [2:0]  mem_size,
    output logic [4:0]  rd_addr,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic        md_busy,
    output logic        illegal
);
    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // is_load is internal: it lets the hazard check see a LOAD sitting in ID/EX
    typedef struct packed {
        logic       vld;
        logic       illegal;
        logic       is_load;
        logic       pc_sel;
        logic       br_unsign;
        logic       op1_sel;
        logic       op2_sel;
        logic       rd_wren;
        logic       mem_wren;
        logic [4:0] alu;
        logic [1:0] wb_sel;
        logic [2:0] mem_size;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ctrl_t;

    typedef enum logic {RUN = 1'b0, MDIV = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d, dec;
    logic             dec_mop;
    logic             rs1_used, rs2_used, hazard;

    logic [6:0] opc;
    logic [2:0] f3;
    assign opc = instr[6:0];
    assign f3  = instr[14:12];

    // ALU op for R/I arithmetic; sub only exists in R-type, shifts split on bit 30
    function automatic logic [4:0] arith_op(input logic [2:0] fn3, input logic b30,
                                            input logic is_r);
        case (fn3)
            3'b000:  arith_op = (is_r && b30) ? 5'd1 : 5'd0;
            3'b001:  arith_op = 5'd2;
            3'b010:  arith_op = 5'd3;
            3'b011:  arith_op = 5'd4;
            3'b100:  arith_op = 5'd5;
            3'b101:  arith_op = b30 ? 5'd6 : 5'd7;
            3'b110:  arith_op = 5'd8;
            default: arith_op = 5'd9;
        endcase
    endfunction

    // Decode the incoming instruction into a candidate bundle
    always_comb begin
        dec      = '0;
        dec_mop  = 1'b0;
        dec.vld  = 1'b1;
        dec.rd   = instr[11:7];
        dec.rs1  = instr[19:15];
        dec.rs2  = instr[24:20];
        case (opc)
            OP_R: begin
                if (instr[31:25] == 7'b0000001) begin
                    if (EN_MEXT) begin
                        dec_mop       = 1'b1;
                        dec.alu       = {2'b10, f3};
                        dec.rd_wren   = 1'b1;
                        dec.br_unsign = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else begin
                    dec.alu       = arith_op(f3, instr[30], 1'b1);
                    dec.rd_wren   = 1'b1;
                    dec.br_unsign = (f3 != 3'b010);
                end
            end
            OP_I: begin
                dec.alu       = arith_op(f3, instr[30], 1'b0);
                dec.rd_wren   = 1'b1;
                dec.op2_sel   = 1'b1;
                dec.br_unsign = !((f3 == 3'b010) || (f3 == 3'b101 && instr[30]));
            end
            OP_LOAD: begin
                dec.is_load   = 1'b1;
                dec.rd_wren   = 1'b1;
                dec.op2_sel   = 1'b1;
                dec.wb_sel    = 2'b10;
                dec.mem_size  = f3;
                dec.br_unsign = 1'b1;
            end
            OP_STORE: begin
                dec.mem_wren  = 1'b1;
                dec.op2_sel   = 1'b1;
                dec.mem_size  = f3;
                dec.br_unsign = 1'b1;
            end
            OP_BRANCH: begin
                dec.pc_sel  = 1'b1;
                dec.op1_sel = 1'b1;
                dec.wb_sel  = 2'b01;
                case (f3)
                    3'b001:  dec.alu = 5'd1;
                    3'b100:  dec.alu = 5'd2;
                    3'b101:  dec.alu = 5'd3;
                    3'b110:  dec.alu = 5'd4;
                    3'b111:  dec.alu = 5'd5;
                    default: dec.alu = 5'd0;
                endcase
                dec.br_unsign = !(f3 == 3'b000 || f3 == 3'b001 ||
                                  f3 == 3'b100 || f3 == 3'b101);
            end
            OP_JAL: begin
                dec.pc_sel    = 1'b1;
                dec.op1_sel   = 1'b1;
                dec.wb_sel    = 2'b01;
                dec.rd_wren   = 1'b1;
                dec.br_unsign = 1'b1;
            end
            OP_JALR: begin
                dec.pc_sel    = 1'b1;
                dec.op2_sel   = 1'b1;
                dec.rd_wren   = 1'b1;
                dec.br_unsign = 1'b1;
            end
            OP_LUI: begin
                dec.rd_wren   = 1'b1;
                dec.br_unsign = 1'b1;
            end
            OP_AUIPC: begin
                dec.pc_sel    = 1'b1;
                dec.rd_wren   = 1'b1;
                dec.br_unsign = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    // Load-use: a LOAD in ID/EX writing a register the incoming instruction reads
    assign rs1_used = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
    assign rs2_used = (opc == OP_R || opc == OP_STORE || opc == OP_BRANCH);
    assign hazard   = ctrl_q.vld && ctrl_q.is_load && (ctrl_q.rd != 5'd0) && instr_vld &&
                      ((rs1_used && dec.rs1 == ctrl_q.rd) || (rs2_used && dec.rs2 == ctrl_q.rd));

    // Next state: flush beats everything, MDIV holds the bundle, RUN advances on ex_ready
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        id_ready = 1'b0;
        if (flush) begin
            state_d = RUN;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else if (state_q == MDIV) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) state_d = RUN;
        end else if (ex_ready) begin
            id_ready = instr_vld && !hazard;
            if (id_ready) begin
                ctrl_d = dec;
                if (dec_mop && (MUL_LAT > 1)) begin
                    state_d = MDIV;
                    cnt_d   = CNT_W'(MUL_LAT - 1);
                end
            end else begin
                ctrl_d = '0;
            end
        end
    end

    // ID/EX register, FSM state and M-op countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctrl_vld   = ctrl_q.vld;
    assign illegal    = ctrl_q.illegal;
    assign pc_sel     = ctrl_q.pc_sel;
    assign br_unsign  = ctrl_q.br_unsign;
    assign op1_sel    = ctrl_q.op1_sel;
    assign op2_sel    = ctrl_q.op2_sel;
    assign rd_wren    = ctrl_q.rd_wren;
    assign mem_wren   = ctrl_q.mem_wren;
    assign alu_opcode = ctrl_q.alu;
    assign wb_sel     = ctrl_q.wb_sel;
    assign mem_size   = ctrl_q.mem_size;
    assign rd_addr    = ctrl_q.rd;
    assign rs1_addr   = ctrl_q.rs1;
    assign rs2_addr   = ctrl_q.rs2;
    assign md_busy    = (state_q == MDIV);

endmodule

// File: doc/pipe_control_unit.md
# pipe_control_unit

Registered decode/control stage for the pipelined RV32I core: decodes the fetched instruction into the same control bundle the single-cycle datapath uses, latches it into the ID/EX register, and adds pipeline behaviour (valid/ready handshake, load-use bubble insertion, flush, and multi-cycle hold for optional M-extension ops). Sits between the IF/ID register and the execute stage; `id_ready` back-pressures fetch.

## Interface
- `EN_MEXT`, 1, 1 = decode RV32M (funct7=0000001 R-type); 0 = treat those encodings as illegal
- `MUL_LAT`, 4, cycles an M op occupies ID/EX (legal 1..16)
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `instr`  in  32  instruction from IF/ID
- `instr_vld`  in  1  `instr` is valid
- `ex_ready`  in  1  execute stage accepts the bundle this cycle
- `flush`  in  1  taken branch/jump redirect; kill ID/EX contents
- `id_ready`  out  1  instruction accepted this cycle (combinational)
- `ctrl_vld`  out  1  bundle holds a real instruction
- `pc_sel`, `br_unsign`, `op1_sel`, `op2_sel`, `rd_wren`, `mem_wren`  out  1 each  registered controls
- `alu_opcode`  out  5  registered ALU/branch op
- `wb_sel`  out  2  registered writeback select
- `mem_size`  out  3  registered funct3 for load/store
- `rd_addr`, `rs1_addr`, `rs2_addr`  out  5 each  registered register fields
- `md_busy`  out  1  M op still executing
- `illegal`  out  1  registered unknown-opcode flag

## Operation
- Opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- alu_opcode: add 0, sub 1, sll 2, slt 3, sltu 4, xor 5, sra 6, srl 7, or 8, and 9; I-type same by funct3 (srai/srli by instr[30]); LOAD/STORE/JAL/JALR/LUI/AUIPC = 0; BRANCH beq 0, bne 1, blt 2, bge 3, bltu 4, bgeu 5; M ops = 16 + funct3.
- br_unsign = 0 for slt, slti, srai, beq, bne, blt, bge; else 1.
- pc_sel = 1 for BRANCH, JAL, JALR, AUIPC. rd_wren = 0 for STORE, BRANCH, illegal, bubble. mem_wren = 1 only for STORE.
- op1_sel = 1 for JAL, BRANCH. op2_sel = 1 for LOAD, STORE, I, JALR. wb_sel = 01 JAL/BRANCH, 10 LOAD, else 00.
- Illegal opcode: bundle loads with ctrl_vld=1, illegal=1, rd_wren=0, mem_wren=0, pc_sel=0.
- Bubble: ctrl_vld=0, all controls 0, alu_opcode 0, addresses 0.
- Load-use hazard: bundle holds LOAD with ctrl_vld=1, rd_addr≠0, and incoming valid instr reads it (rs1 used by all except LUI/AUIPC/JAL; rs2 used by R/STORE/BRANCH). Response: id_ready=0, bubble loaded if ex_ready.
- FSM: RUN, MDIV. Counter width clog2(MUL_LAT+1).
- RUN: advance = ex_ready. id_ready = ex_ready & instr_vld & ~hazard & ~flush. On advance: load decoded bundle if id_ready, else bubble. Accepted M op with MUL_LAT>1 → MDIV, cnt=MUL_LAT-1.
- MDIV: md_busy=1, id_ready=0, bundle held regardless of ex_ready; cnt decrements each cycle; cnt==1 → RUN next edge.
- flush (highest priority): next edge loads bubble, cnt=0, state RUN; id_ready=0 that cycle. Aborts MDIV.

## Timing
- Reset (async assert): all outputs 0, state RUN, cnt 0; id_ready follows its combinational equation (0 unless ex_ready & instr_vld).
- Decode latency: 1 cycle (accept at edge N, bundle visible after N).
- ex_ready=0 in RUN: bundle, state frozen; id_ready=0.
- M op: bundle visible MUL_LAT cycles; md_busy high for first MUL_LAT-1; next instr accepted in cycle MUL_LAT. MUL_LAT=1 behaves as single-cycle op, md_busy never set.
- Hazard bubble costs exactly 1 cycle; dependent instr accepted next cycle.
- flush coincident with hazard, ex_ready=0 or MDIV: flush wins.

## Test plan
- Reset then `add x3,x1,x2` (0x002081B3), ex_ready=1 -> next cycle ctrl_vld=1, alu_opcode=0, rd_wren=1, rd_addr=3, wb_sel=00.
- `lw x5,0(x1)` then `add x6,x5,x2` -> cycle 2 id_ready=0, bubble loaded; cycle 3 add accepted; with rd=x0 load, no bubble.
- `beq`/`bltu`/`slti`/`sw` sweep -> alu_opcode 0/4/3/0, br_unsign 0/1/0/1, mem_wren only on sw, pc_sel=1 on branches.
- EN_MEXT=1, MUL_LAT=4, `mul x7,x1,x2` -> alu_opcode=16, md_busy high 3 cycles, id_ready=0 throughout, next instr accepted cycle 4; EN_MEXT=0 -> illegal=1.
- flush during MDIV cycle 2 and during ex_ready=0 stall -> next cycle bubble, md_busy=0, state RUN.
- rst_n asserted mid-MDIV asynchronously -> all outputs 0 immediately; opcode 0x7F after reset -> illegal=1, rd_wren=0.
